// File: rtl/rf_wb_pkg.sv
// Shared definitions for the register-file writeback arbiter.
//   XLEN          - datapath width of writeback data
//   REG_ADDR_W    - register index width (index 0 is the hard-wired zero reg)
//   MAX_WAIT_DEF  - default number of cycles EXE may be denied before force-grant
//   arb_state_e   - arbiter priority state
//   wb_req_t      - destination/data pair carried by a writeback request
package rf_wb_pkg;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned REG_ADDR_W   = 5;
  localparam int unsigned MAX_WAIT_DEF = 3;

  typedef enum logic {
    PRI_LSU   = 1'b0,
    FORCE_EXE = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

endpackage

// File: rtl/rf_wb_arb_if.sv
// Handshake bundle between the two writeback requesters (EXE, LSU) and the
// writeback arbiter, plus the register-file write port it drives.
//   master modport - requester side: drives valid/rd/data, observes ready and
//                    the resulting register-file write
//   slave  modport - arbiter side: observes requests, drives ready, write
//                    port and the contention counter
interface rf_wb_arb_if;
  import rf_wb_pkg::*;

  logic                  exe_valid;
  logic [REG_ADDR_W-1:0] exe_rd;
  logic [XLEN-1:0]       exe_data;
  logic                  exe_ready;

  logic                  lsu_valid;
  logic [REG_ADDR_W-1:0] lsu_rd;
  logic [XLEN-1:0]       lsu_data;
  logic                  lsu_ready;

  logic [REG_ADDR_W-1:0] wb_rd_o;
  logic [XLEN-1:0]       wb_data_o;
  logic [XLEN-1:0]       conflict_cnt_o;

  modport master (
    output exe_valid, exe_rd, exe_data,
    input  exe_ready,
    output lsu_valid, lsu_rd, lsu_data,
    input  lsu_ready,
    input  wb_rd_o, wb_data_o, conflict_cnt_o
  );

  modport slave (
    input  exe_valid, exe_rd, exe_data,
    output exe_ready,
    input  lsu_valid, lsu_rd, lsu_data,
    output lsu_ready,
    output wb_rd_o, wb_data_o, conflict_cnt_o
  );

endinterface

// File: rtl/rf_wb_arb.sv
// Register-file writeback arbiter between the ALU (EXE) and load return (LSU).
// LSU wins contention by default; EXE is force-granted after MAX_WAIT
// consecutive denied cycles. Requests with rd=0 are accepted immediately and
// produce no write. The granted write appears on wb_rd_o/wb_data_o one cycle
// after the handshake; wb_rd_o=0 means no write.
//
// Parameters:
//   MAX_WAIT        - denied cycles before EXE is force-granted (1..15)
// Ports:
//   clk, rst_n      - rising-edge clock, asynchronous active-low reset
//   exe_valid/rd/data, exe_ready - ALU writeback request handshake
//   lsu_valid/rd/data, lsu_ready - load-return writeback request handshake
//   wb_rd_o, wb_data_o           - registered register-file write port
//   conflict_cnt_o               - saturating count of contended cycles
// Build option:
//   WB_ARB_PERF_EN  - when defined, conflict_cnt_o is a live counter;
//                     otherwise it is tied to zero with no flops.
module rf_wb_arb
  import rf_wb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  exe_valid,
  input  logic [REG_ADDR_W-1:0] exe_rd,
  input  logic [XLEN-1:0]       exe_data,
  output logic                  exe_ready,

  input  logic                  lsu_valid,
  input  logic [REG_ADDR_W-1:0] lsu_rd,
  input  logic [XLEN-1:0]       lsu_data,
  output logic                  lsu_ready,

  output logic [REG_ADDR_W-1:0] wb_rd_o,
  output logic [XLEN-1:0]       wb_data_o,
  output logic [XLEN-1:0]       conflict_cnt_o
);

  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  arb_state_e            state_q, state_d;
  logic [3:0]            wait_q, wait_d;
  logic                  exe_nz, lsu_nz;
  logic                  exe_grant, lsu_grant;
  wb_req_t               wb_d;

  // A request "contends" only if it would actually write a register.
  assign exe_nz = exe_valid && (exe_rd != '0);
  assign lsu_nz = lsu_valid && (lsu_rd != '0);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PRI_LSU;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      PRI_LSU: begin
        if (wait_d == WAIT_LIMIT) state_d = FORCE_EXE;
      end
      FORCE_EXE: begin
        if ((exe_grant && exe_nz) || !exe_valid) state_d = PRI_LSU;
      end
      default: state_d = PRI_LSU;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: grants and the write to be registered
  // ---------------------------------------------------------------------------
  // Grants are computed without reset so that rst_n only reaches the ready
  // ports combinationally and never a flop D input; during reset all flops
  // are held, so the ungated grants have no effect there.
  always_comb begin
    exe_grant = 1'b0;
    lsu_grant = 1'b0;
    wb_d      = '0;
    exe_grant = exe_valid && (!exe_nz || !lsu_nz || (state_q == FORCE_EXE));
    lsu_grant = lsu_valid && (!lsu_nz || !exe_nz || (state_q == PRI_LSU));
    // At most one nonzero-rd grant per cycle by construction.
    if (exe_grant && exe_nz) begin
      wb_d.rd   = exe_rd;
      wb_d.data = exe_data;
    end else if (lsu_grant && lsu_nz) begin
      wb_d.rd   = lsu_rd;
      wb_d.data = lsu_data;
    end
  end

  assign exe_ready = rst_n && exe_grant;
  assign lsu_ready = rst_n && lsu_grant;

  // ---------------------------------------------------------------------------
  // EXE starvation counter
  // ---------------------------------------------------------------------------
  always_comb begin
    wait_d = '0;
    if (exe_nz && !exe_grant) begin
      wait_d = (wait_q == 4'hF) ? wait_q : wait_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered writeback port
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_rd_o   <= '0;
      wb_data_o <= '0;
    end else begin
      wb_rd_o   <= wb_d.rd;
      wb_data_o <= wb_d.data;
    end
  end

  // ---------------------------------------------------------------------------
  // Contention counter
  // ---------------------------------------------------------------------------
`ifdef WB_ARB_PERF_EN
  logic [XLEN-1:0] conflict_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_q <= '0;
    end else if (exe_nz && lsu_nz && (conflict_q != '1)) begin
      conflict_q <= conflict_q + XLEN'(1);
    end
  end

  assign conflict_cnt_o = conflict_q;
`else
  assign conflict_cnt_o = '0;
`endif

endmodule

// File: tb/tb_rf_wb_arb.sv
// Scoreboard bench for rf_wb_arb (MAX_WAIT=3). The driver applies directed
// vectors on the falling edge, checks the combinational ready outputs, and
// queues the hand-computed register-file write expected one edge later; a
// separate monitor pops and compares after every rising edge.
module tb_rf_wb_arb;
  import rf_wb_pkg::*;

  typedef struct {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
    logic [XLEN-1:0]       conf;
  } exp_t;

`ifdef WB_ARB_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk;
  logic rst_n;
  rf_wb_arb_if bus ();

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned conf_model = 0;
  bit          mon_en = 1'b0;
  exp_t        sb[$];

  rf_wb_arb #(.MAX_WAIT(3)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .exe_valid      (bus.exe_valid),
    .exe_rd         (bus.exe_rd),
    .exe_data       (bus.exe_data),
    .exe_ready      (bus.exe_ready),
    .lsu_valid      (bus.lsu_valid),
    .lsu_rd         (bus.lsu_rd),
    .lsu_data       (bus.lsu_data),
    .lsu_ready      (bus.lsu_ready),
    .wb_rd_o        (bus.wb_rd_o),
    .wb_data_o      (bus.wb_data_o),
    .conflict_cnt_o (bus.conflict_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: one expected write per clocked vector.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (mon_en) begin
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("wb_rd",    32'(bus.wb_rd_o),   32'(e.rd));
        chk("wb_data",  bus.wb_data_o,      e.data);
        chk("conflict", bus.conflict_cnt_o, e.conf);
      end else begin
        chk("spurious_wb", 32'(bus.wb_rd_o), 32'd0);
      end
    end
  end

  task automatic drive(input logic ev, input logic [4:0] erd, input logic [31:0] ed,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
    bus.exe_valid = ev;
    bus.exe_rd    = erd;
    bus.exe_data  = ed;
    bus.lsu_valid = lv;
    bus.lsu_rd    = lrd;
    bus.lsu_data  = ld;
  endtask

  task automatic apply(input string tag,
                       input logic ev, input logic [4:0] erd, input logic [31:0] ed,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                       input logic xer, input logic xlr,
                       input logic [4:0] xrd, input logic [31:0] xd);
    exp_t e;
    @(negedge clk);
    drive(ev, erd, ed, lv, lrd, ld);
    if (ev && (erd != 0) && lv && (lrd != 0)) conf_model++;
    e.rd   = xrd;
    e.data = xd;
    e.conf = PERF ? 32'(conf_model) : 32'd0;
    sb.push_back(e);
    #1;
    chk({tag, "_exe_ready"}, 32'(bus.exe_ready), 32'(xer));
    chk({tag, "_lsu_ready"}, 32'(bus.lsu_ready), 32'(xlr));
  endtask

  task automatic idle(input string tag);
    apply(tag, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 0, 5'd0, 32'd0);
  endtask

  initial begin
    logic [9:0] exe_win;
    exe_win = 10'b0010001000;

    // Reset state with requests present: no ready, no write, no count.
    rst_n = 1'b0;
    drive(1, 5'd5, 32'h55, 1, 5'd6, 32'h66);
    #12;
    chk("reset_exe_ready", 32'(bus.exe_ready), 32'd0);
    chk("reset_lsu_ready", 32'(bus.lsu_ready), 32'd0);
    chk("reset_wb_rd",     32'(bus.wb_rd_o),   32'd0);
    chk("reset_wb_data",   bus.wb_data_o,      32'd0);
    chk("reset_conflict",  bus.conflict_cnt_o, 32'd0);
    @(negedge clk);
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    idle("idle0");
    // Sole EXE request granted immediately.
    apply("exe_only", 1, 5'd5, 32'h11, 0, 5'd0, 32'd0, 1, 0, 5'd5, 32'h11);
    idle("idle1");
    // rd=0 request accepted alongside LSU; only LSU writes, not contended.
    apply("exe_rd0", 1, 5'd0, 32'hAA, 1, 5'd7, 32'h77, 1, 1, 5'd7, 32'h77);
    apply("both_rd0", 1, 5'd0, 32'hAB, 1, 5'd0, 32'hCD, 1, 1, 5'd0, 32'd0);
    apply("lsu_rd0", 1, 5'd6, 32'h66, 1, 5'd0, 32'hEE, 1, 1, 5'd6, 32'h66);

    // Both held valid for 10 cycles: EXE force-granted on cycles 3 and 7.
    for (int i = 0; i < 10; i++) begin
      if (exe_win[i])
        apply("held", 1, 5'd1, 32'hE1, 1, 5'd2, 32'h22, 1, 0, 5'd1, 32'hE1);
      else
        apply("held", 1, 5'd1, 32'hE1, 1, 5'd2, 32'h22, 0, 1, 5'd2, 32'h22);
    end
    idle("idle2");

    // Contention, then EXE served once LSU drops.
    apply("cont_lsu", 1, 5'd3, 32'h33, 1, 5'd4, 32'h44, 0, 1, 5'd4, 32'h44);
    apply("cont_exe", 1, 5'd3, 32'h33, 0, 5'd0, 32'd0, 1, 0, 5'd3, 32'h33);

    // Same destination: two separate writes, LSU first.
    apply("same_lsu", 1, 5'd8, 32'h81, 1, 5'd8, 32'h82, 0, 1, 5'd8, 32'h82);
    apply("same_exe", 1, 5'd8, 32'h81, 0, 5'd0, 32'd0, 1, 0, 5'd8, 32'h81);
    idle("idle3");

    // Reach FORCE_EXE, then EXE withdraws: FSM must fall back to LSU priority.
    for (int i = 0; i < 3; i++)
      apply("pre_force", 1, 5'd10, 32'hA0, 1, 5'd11, 32'hB0, 0, 1, 5'd11, 32'hB0);
    apply("force_drop", 0, 5'd0, 32'd0, 1, 5'd12, 32'hC0, 0, 1, 5'd12, 32'hC0);
    apply("post_drop", 1, 5'd10, 32'hA1, 1, 5'd13, 32'hD0, 0, 1, 5'd13, 32'hD0);
    apply("post_exe", 1, 5'd10, 32'hA1, 0, 5'd0, 32'd0, 1, 0, 5'd10, 32'hA1);

    // Write of rd=9 in flight when reset asserts.
    apply("pre_rst", 0, 5'd0, 32'd0, 1, 5'd9, 32'h99, 0, 1, 5'd9, 32'h99);
    @(posedge clk);
    #3;
    chk("pre_rst_sb_drained", 32'(sb.size()), 32'd0);
    mon_en = 1'b0;
    drive(1, 5'd5, 32'h55, 1, 5'd6, 32'h66);
    rst_n = 1'b0;
    #1;
    chk("midrst_wb_rd",     32'(bus.wb_rd_o),   32'd0);
    chk("midrst_wb_data",   bus.wb_data_o,      32'd0);
    chk("midrst_exe_ready", 32'(bus.exe_ready), 32'd0);
    chk("midrst_lsu_ready", 32'(bus.lsu_ready), 32'd0);
    chk("midrst_conflict",  bus.conflict_cnt_o, 32'd0);
    conf_model = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    idle("post_rst0");
    idle("post_rst1");
    apply("post_rst_exe", 1, 5'd5, 32'h55, 0, 5'd0, 32'd0, 1, 0, 5'd5, 32'h55);
    idle("post_rst2");

    @(posedge clk);
    #3;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_wb_arb.md
RF_WB_ARB -- requirements
Module: rf_wb_arb

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 3: consecutive cycles EXE may be denied before it is force-granted; legal range 1..15.
REQ-002 SHALL have port clk  input  1  clock; all flops rising-edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port exe_valid  input  1  ALU writeback request valid.
REQ-005 SHALL have port exe_rd  input  5  ALU destination register.
REQ-006 SHALL have port exe_data  input  32  ALU result.
REQ-007 SHALL have port exe_ready  output  1  ALU request accepted this cycle.
REQ-008 SHALL have port lsu_valid  input  1  load-return writeback request valid.
REQ-009 SHALL have port lsu_rd  input  5  load destination register.
REQ-010 SHALL have port lsu_data  input  32  load data.
REQ-011 SHALL have port lsu_ready  output  1  load request accepted this cycle.
REQ-012 SHALL have port wb_rd_o  output  5  register-file write index; 0 = no write.
REQ-013 SHALL have port wb_data_o  output  32  register-file write data.
REQ-014 SHALL have port conflict_cnt_o  output  32  count of contended cycles.

Function
REQ-015 SHALL transfer a request only when valid and ready are both high in the same cycle; ready is combinational from valid, rd and arbiter state.
REQ-016 SHALL require requesters to hold valid, rd and data stable until transfer; the block holds no request buffer.
REQ-017 SHALL accept a request with rd=0 in the same cycle it is presented, regardless of the other requester, producing no write.
REQ-018 SHALL grant a sole valid nonzero-rd request in the cycle it is presented.
REQ-019 SHALL, when both carry nonzero rd, grant LSU in state PRI_LSU and EXE in state FORCE_EXE; the loser sees ready=0.
REQ-020 SHALL apply no merging or ordering check when both target the same rd; each grant produces its own write.
REQ-021 SHALL register the granted rd/data onto wb_rd_o/wb_data_o on the next clk edge (latency 1); cycles without a nonzero-rd grant drive wb_rd_o=0, wb_data_o=0.
REQ-022 SHALL keep a 4-bit wait counter incremented each cycle EXE is valid with nonzero rd and not granted; cleared on EXE grant or EXE valid low.
REQ-023 SHALL move PRI_LSU -> FORCE_EXE at the edge where the counter reaches MAX_WAIT.
REQ-024 SHALL move FORCE_EXE -> PRI_LSU at the edge after an EXE grant, or if exe_valid is low.

Reset
REQ-025 SHALL on rst_n low immediately drive wb_rd_o=0, wb_data_o=0, conflict_cnt_o=0, state PRI_LSU, counter 0, and hold exe_ready=lsu_ready=0.
REQ-026 SHALL drop any in-flight registered write when reset asserts mid-operation; the write is not replayed after release.

Configuration
REQ-027 SHALL, with WB_ARB_PERF_EN defined, increment conflict_cnt_o each cycle both requests are valid with nonzero rd, saturating at 0xFFFFFFFF.
REQ-028 SHALL, without WB_ARB_PERF_EN, tie conflict_cnt_o to 0 and instantiate no counter flops.

Structure
REQ-029 SHALL take XLEN=32, REG_ADDR_W=5, the state typedef (PRI_LSU, FORCE_EXE) and the MAX_WAIT default from shared package rf_wb_pkg.
REQ-030 SHALL be a single module with no sub-modules.

Verification
REQ-031 SHALL cover: EXE only, rd=5, data=0x11 -> exe_ready=1 same cycle; next cycle wb_rd_o=5, wb_data_o=0x11.
REQ-032 SHALL cover: both valid, exe_rd=3, lsu_rd=4 -> lsu_ready=1, exe_ready=0; next cycle wb_rd_o=4; EXE granted the following cycle once LSU drops.
REQ-033 SHALL cover: both held valid, MAX_WAIT=3 -> LSU granted cycles 0-2, EXE granted cycle 3, LSU cycle 4.
REQ-034 SHALL cover: exe_rd=0 with lsu_rd=7 both valid -> both ready same cycle; next cycle wb_rd_o=7 only; conflict_cnt_o unchanged.
REQ-035 SHALL cover: rst_n pulsed low while wb_rd_o=9 -> wb_rd_o=0 immediately; no write of 9 after release.
REQ-036 SHALL cover: WB_ARB_PERF_EN defined, 10 contended cycles -> conflict_cnt_o=10; undefined -> 0.
